// File: rtl/char_pkg.sv
// Shared character definitions for the case-conversion datapath.
// Both this feed FIFO and the downstream toupper stage import this package.
package char_pkg;

  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_Z = 8'h7A;
  localparam int         CASE_BIT     = 5;

  typedef logic [7:0] ascii_t;

  typedef struct packed {
    logic   lower;
    ascii_t ch;
  } char_entry_t;

  // Flags bytes in the 'a'..'z' range; these are the only bytes whose case bit gets cleared downstream
  function automatic logic is_lower(input ascii_t c);
    return (c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_Z);
  endfunction

endpackage

// File: rtl/char_feed_fifo.sv
// Upstream feed stage: buffers ASCII bytes in a small first-word-fall-through
// FIFO, tags lowercase bytes at push time and counts the lowercase bytes handed
// downstream. DEPTH must be a power of two so the pointers wrap naturally.
module char_feed_fifo
  import char_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  output logic                         out_lower,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             lower_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  char_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  char_entry_t      hold_q;
  char_entry_t      head;
  logic             push;
  logic             pop;

  // Handshake flags come straight from occupancy; flush suppresses the actual transfers
  // but leaves ready/valid as they were until the clock edge.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head entry falls through; when empty the last popped entry is held instead.
  assign head      = out_valid ? mem[rd_ptr] : hold_q;
  assign out_data  = head.ch;
  assign out_lower = head.lower;

  // Pointer, occupancy, hold register and lowercase statistics bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      lower_cnt <= '0;
      hold_q    <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      lower_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hold_q <= mem[rd_ptr];
        if (head.lower && (lower_cnt != {CNT_W{1'b1}})) begin
          lower_cnt <= lower_cnt + CNT_W'(1);
        end
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write with the lowercase tag computed once on the way in; not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {is_lower(in_data), in_data};
    end
  end

endmodule

// File: tb/tb_char_feed_fifo.sv
// Directed self-checking bench for char_feed_fifo (DEPTH=4, CNT_W=16).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_char_feed_fifo;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_lower;
  logic        out_ready;
  logic [2:0]  level;
  logic [15:0] lower_cnt;

  int total = 0;
  int bad   = 0;

  char_feed_fifo #(.DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lower (out_lower),
    .out_ready (out_ready),
    .level     (level),
    .lower_cnt (lower_cnt)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] d,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [7:0] exp_byte;
  logic       exp_tag;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // 1: reset and idle
    #2;
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_out_lower", 32'(out_lower), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("idle_in_ready", 32'(in_ready), 32'h1);
      checkOutput("idle_out_valid", 32'(out_valid), 32'h0);
      checkOutput("idle_level", 32'(level), 32'h0);
      checkOutput("idle_lower_cnt", 32'(lower_cnt), 32'h0);
      tick();
    end

    // 2: fill with 'a','Z','z','{' while consumer stalls, then drain
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    tick();
    checkOutput("t2_latency_valid", 32'(out_valid), 32'h1);
    checkOutput("t2_level1", 32'(level), 32'h1);
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h7A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h7B, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t2_full_level", 32'(level), 32'h4);
    checkOutput("t2_full_in_ready", 32'(in_ready), 32'h0);
    checkOutput("t2_head_data", 32'(out_data), 32'h61);
    checkOutput("t2_head_lower", 32'(out_lower), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t2_pop0_data", 32'(out_data), 32'h61);
    checkOutput("t2_pop0_lower", 32'(out_lower), 32'h1);
    tick();
    checkOutput("t2_pop1_data", 32'(out_data), 32'h5A);
    checkOutput("t2_pop1_lower", 32'(out_lower), 32'h0);
    tick();
    checkOutput("t2_pop2_data", 32'(out_data), 32'h7A);
    checkOutput("t2_pop2_lower", 32'(out_lower), 32'h1);
    tick();
    checkOutput("t2_pop3_data", 32'(out_data), 32'h7B);
    checkOutput("t2_pop3_lower", 32'(out_lower), 32'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t2_empty_valid", 32'(out_valid), 32'h0);
    checkOutput("t2_lower_cnt", 32'(lower_cnt), 32'h2);

    // 3: full FIFO offered a byte while popping: pop only, push next cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h45, 1'b1, 1'b0);
    checkOutput("t3_full_in_ready", 32'(in_ready), 32'h0);
    checkOutput("t3_full_level", 32'(level), 32'h4);
    tick();
    applyStimulus(1'b1, 8'h45, 1'b0, 1'b0);
    checkOutput("t3_after_pop_level", 32'(level), 32'h3);
    checkOutput("t3_after_pop_in_ready", 32'(in_ready), 32'h1);
    checkOutput("t3_after_pop_head", 32'(out_data), 32'h42);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t3_refill_level", 32'(level), 32'h4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_drain_data", 32'(out_data), 32'(8'h42 + i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_drain_level", 32'(level), 32'h0);
    checkOutput("t3_lower_cnt", 32'(lower_cnt), 32'h2);

    // 4: stream 0x60..0x7B at a steady level of 2 with push and pop every cycle
    applyStimulus(1'b1, 8'h60, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0);
    tick();
    for (int i = 2; i < 28; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      exp_byte = 8'(8'h60 + i - 2);
      exp_tag  = (i - 2 >= 1) && (i - 2 <= 26);
      checkOutput("t4_stream_level", 32'(level), 32'h2);
      checkOutput("t4_stream_data", 32'(out_data), 32'(exp_byte));
      checkOutput("t4_stream_lower", 32'(out_lower), 32'(exp_tag));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4_tail0_data", 32'(out_data), 32'h7A);
    checkOutput("t4_tail0_lower", 32'(out_lower), 32'h1);
    tick();
    checkOutput("t4_tail1_data", 32'(out_data), 32'h7B);
    checkOutput("t4_tail1_lower", 32'(out_lower), 32'h0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_empty_valid", 32'(out_valid), 32'h0);
    checkOutput("t4_lower_cnt", 32'(lower_cnt), 32'd28);

    // 5: flush at level 3 while both sides are active
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h64, 1'b1, 1'b1);
    checkOutput("t5_preflush_level", 32'(level), 32'h3);
    checkOutput("t5_preflush_valid", 32'(out_valid), 32'h1);
    checkOutput("t5_preflush_ready", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_flush_level", 32'(level), 32'h0);
    checkOutput("t5_flush_valid", 32'(out_valid), 32'h0);
    checkOutput("t5_flush_lower_cnt", 32'(lower_cnt), 32'h0);
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_post_flush_head", 32'(out_data), 32'h41);
    checkOutput("t5_post_flush_level", 32'(level), 32'h1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5_post_pop_cnt", 32'(lower_cnt), 32'h0);

    // 6: asynchronous reset with two entries in flight
    applyStimulus(1'b1, 8'h70, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h71, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_prereset_level", 32'(level), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_level", 32'(level), 32'h0);
    checkOutput("t6_async_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_post_reset_data", 32'(out_data), 32'h62);
    checkOutput("t6_post_reset_lower", 32'(out_lower), 32'h1);
    checkOutput("t6_post_reset_level", 32'(level), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
